// File: rtl/pu_buf_pkg.sv
// Shared constants and entry layout for the PU read buffer.
// Entries are stored as {last, data} so the transfer boundary travels with the word.
package pu_buf_pkg;

    localparam int BUF_DATA_WIDTH  = 64;
    localparam int BUF_ADDR_WIDTH  = 6;
    localparam int BUF_DEPTH       = 1 << BUF_ADDR_WIDTH;
    localparam int BUF_ENTRY_WIDTH = BUF_DATA_WIDTH + 1;

    typedef struct packed {
        logic                      last;
        logic [BUF_DATA_WIDTH-1:0] data;
    } buf_entry_t;

    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/pu_read_buffer_server_if.sv
// Fill-side and controller-side signals of the PU read buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface pu_read_buffer_server_if
    import pu_buf_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
);
    logic                  flush;
    logic                  fill_valid;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  fill_last;
    logic                  fill_ready;
    logic                  buffer_read_req;
    logic                  buffer_read_data_valid;
    logic [DATA_WIDTH-1:0] buffer_read_data_out;
    logic                  buffer_read_last;
    logic                  buffer_read_empty;
    logic [ADDR_WIDTH:0]   occupancy;
    logic                  underflow_err;

    modport slave (
        input  flush, fill_valid, fill_data, fill_last, buffer_read_req,
        output fill_ready, buffer_read_data_valid, buffer_read_data_out,
               buffer_read_last, buffer_read_empty, occupancy, underflow_err
    );

    modport master (
        output flush, fill_valid, fill_data, fill_last, buffer_read_req,
        input  fill_ready, buffer_read_data_valid, buffer_read_data_out,
               buffer_read_last, buffer_read_empty, occupancy, underflow_err
    );
endinterface

// File: rtl/pu_buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Only the read register is reset; the array itself is left uninitialised.
module pu_buf_ram #(
    parameter int WIDTH      = 65,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Holds the last popped entry when no read is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_reg <= '0;
        else if (re)
            rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/pu_read_buffer_server.sv
// Buffer read responder for the PU controller: FIFO of {last, data} words with
// one-cycle pop latency, full/empty from registered state, sticky underflow flag.
module pu_read_buffer_server
    import pu_buf_pkg::*;
#(
    parameter int DATA_WIDTH = BUF_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
    input logic                     clk,
    input logic                     reset,
    pu_read_buffer_server_if.slave  bus
);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_reg;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg;
    logic [ADDR_WIDTH:0]   occ_reg;
    logic                  valid_reg;
    logic                  underflow_reg;

    logic                  fill_ready;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH:0]   rd_entry;

    assign fill_ready = (occ_reg != FULL_COUNT);
    assign empty      = (occ_reg == '0);

    // Flush overrides both sides in the same cycle.
    assign push = bus.fill_valid && fill_ready && !bus.flush;
    assign pop  = bus.buffer_read_req && !empty && !bus.flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            valid_reg     <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            valid_reg     <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            valid_reg <= pop;
            if (bus.buffer_read_req && empty)
                underflow_reg <= 1'b1;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            case ({push, pop})
                2'b10:   occ_reg <= occ_reg + ONE_COUNT;
                2'b01:   occ_reg <= occ_reg - ONE_COUNT;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    pu_buf_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wr_ptr_reg),
        .wdata ({bus.fill_last, bus.fill_data}),
        .re    (pop),
        .raddr (rd_ptr_reg),
        .rdata (rd_entry)
    );

    assign bus.fill_ready             = fill_ready;
    assign bus.buffer_read_empty      = empty;
    assign bus.occupancy              = occ_reg;
    assign bus.underflow_err          = underflow_reg;
    assign bus.buffer_read_data_valid = valid_reg;
    assign bus.buffer_read_data_out   = rd_entry[DATA_WIDTH-1:0];
    assign bus.buffer_read_last       = rd_entry[DATA_WIDTH];
endmodule

// File: tb/tb_pu_read_buffer_server.sv
// Randomised bench for pu_read_buffer_server against a queue-based reference model.
module tb_pu_read_buffer_server;
    import pu_buf_pkg::*;

    logic clk;
    logic reset;

    pu_read_buffer_server_if bus ();

    pu_read_buffer_server dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    buf_entry_t  q[$];
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_last;
    logic        m_uf;
    logic        push_ok;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        m_uf    = 1'b0;
    endtask

    task automatic check_state();
        check("valid",     64'(bus.buffer_read_data_valid), 64'(m_valid));
        check("data_out",  bus.buffer_read_data_out, m_data);
        check("last",      64'(bus.buffer_read_last), 64'(m_last));
        check("occupancy", 64'(bus.occupancy), 64'(q.size()));
        check("underflow", 64'(bus.underflow_err), 64'(m_uf));
        check("empty",     64'(bus.buffer_read_empty), 64'(q.size() == 0));
        check("ready",     64'(bus.fill_ready), 64'(q.size() != BUF_DEPTH));
    endtask

    task automatic drive_idle();
        bus.flush           = 1'b0;
        bus.fill_valid      = 1'b0;
        bus.fill_data       = '0;
        bus.fill_last       = 1'b0;
        bus.buffer_read_req = 1'b0;
    endtask

    // One clock cycle: drive at negedge, predict from queue rules, check after posedge.
    task automatic step(input logic fv, input logic [63:0] fd, input logic fl,
                        input logic rq, input logic fs);
        int sz;
        buf_entry_t e;
        @(negedge clk);
        bus.flush           = fs;
        bus.fill_valid      = fv;
        bus.fill_data       = fd;
        bus.fill_last       = fl;
        bus.buffer_read_req = rq;
        sz      = q.size();
        push_ok = 1'b0;
        if (fs) begin
            q.delete();
            m_valid = 1'b0;
            m_uf    = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (rq && sz == 0)
                m_uf = 1'b1;
            if (rq && sz > 0) begin
                e       = q.pop_front();
                m_valid = 1'b1;
                m_data  = e.data;
                m_last  = e.last;
            end
            if (fv && sz < BUF_DEPTH) begin
                push_ok = 1'b1;
                e.last  = fl;
                e.data  = fd;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_state();
        if (m_valid)
            $display("pop data=%h last=%b occ=%0d", bus.buffer_read_data_out,
                     bus.buffer_read_last, bus.occupancy);
        drive_idle();
    endtask

    initial begin
        int next_val;
        logic fv;
        logic rq;

        drive_idle();
        reset = 1'b1;
        model_reset();
        #1;
        check_state();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: three words, back-to-back pops
        step(1, 64'h1111_1111_1111_1111, 0, 0, 0);
        step(1, 64'h2222_2222_2222_2222, 0, 0, 0);
        step(1, 64'h3333_3333_3333_3333, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // 2: fill to 64, extra push held off, one pop frees a slot
        for (int i = 0; i < BUF_DEPTH; i++)
            step(1, 64'(i) | 64'h0B00_0000_0000_0000, i[0], 0, 0);
        step(1, 64'hFFFF_0000_FFFF_0000, 1, 0, 0);
        step(1, 64'hEEEE_0000_EEEE_0000, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < BUF_DEPTH - 1; i++)
            step(0, 0, 0, 1, 0);

        // 3: request while empty sets sticky underflow
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(1, 64'h4444, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // 4: push and request in same cycle on empty FIFO
        step(1, 64'hAAAA_5555_AAAA_5555, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);

        // 5: flush with simultaneous push/pop, then reuse
        for (int i = 0; i < 10; i++)
            step(1, 64'h5000 + 64'(i), 0, 0, 0);
        step(1, 64'h5FFF, 1, 1, 1);
        step(1, 64'hDEAD, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // 6: wraparound with random gaps
        next_val = 0;
        for (int cyc = 0; cyc < 3000 && (next_val < 200 || q.size() > 0); cyc++) begin
            fv = (next_val < 200) && ($urandom_range(0, 3) != 0);
            rq = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            step(fv, 64'hC0DE_0000_0000_0000 | 64'(next_val), (next_val % 8) == 7, rq, 0);
            if (push_ok)
                next_val++;
        end
        check("wrap_pushed", 64'(next_val), 64'd200);
        check("wrap_drained", 64'(bus.occupancy), 64'd0);

        // Async reset mid-transfer
        for (int i = 0; i < 5; i++)
            step(1, 64'h7000 + 64'(i), 0, i == 2, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_state();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1, 64'h1234_5678_9ABC_DEF0, 1, 0, 0);
        step(0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
